phase_acc_sweep: RTL

DDS phase accumulator that feeds the downstream phase-offset/ROM-address stage.
- Each cycle, adds an active frequency tuning word to an ACC_W-bit accumulator.
- Outputs the top OUT_W bits as `result`.
- Supports fixed-frequency and triangular frequency-sweep operation.
- New settings are accepted over a valid/ready handshake and applied glitch-free at the next accumulator wrap.

---
 rtl/dac_pkg.sv | 23 ++
 rtl/sweep_tick_gen.sv | 36 +++
 rtl/phase_acc_sweep.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// ============================================================================
// dac_pkg: shared types and defaults for the DDS phase/ROM pipeline. Rev 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIXED = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } sweep_state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SWEEP = 1'b1;

  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 8;

endpackage

`default_nettype wire

// File: rtl/sweep_tick_gen.sv
// ============================================================================
// sweep_tick_gen: one-cycle tick every STEP_CYCLES enabled cycles. Rev 1.0
// ============================================================================
`default_nettype none

module sweep_tick_gen #(
  parameter int STEP_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // clear restarts a full period so the first tick lands STEP_CYCLES enabled cycles later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= RELOAD;
    end else if (enable) begin
      cnt <= (cnt == '0) ? RELOAD : (cnt - CNT_W'(1));
    end
  end

  assign tick = enable && !clear && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/phase_acc_sweep.sv
// ============================================================================
// phase_acc_sweep: DDS phase accumulator; optional triangular sweep when
// FREQ_SWEEP_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module phase_acc_sweep
  import dac_pkg::*;
#(
  parameter int ACC_W       = DEF_ACC_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int STEP_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_fword,
  input  logic [ACC_W-1:0] cfg_fstop,
  input  logic [ACC_W-1:0] cfg_fstep,
  input  logic             cfg_mode,
  output logic [OUT_W-1:0] result,
  output logic             wrap,
  output logic [ACC_W-1:0] fword_cur
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fstart_sh;
  logic [ACC_W-1:0] fword_nxt;
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic             pending;
  logic             capture;
  logic             apply;
  sweep_state_t     state;
  sweep_state_t     state_nxt;

  assign add_full  = {1'b0, acc} + {1'b0, fword_cur};
  assign carry     = add_full[ACC_W];
  assign cfg_ready = !pending;
  assign capture   = cfg_valid && !pending;
  // a capture never coincides with an apply: apply needs pending already set
  assign apply     = pending && (!enable || carry);
  assign result    = acc[ACC_W-1 -: OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      wrap      <= 1'b0;
      pending   <= 1'b0;
      fstart_sh <= '0;
    end else begin
      if (enable) begin
        acc <= add_full[ACC_W-1:0];
      end
      wrap <= enable && carry;
      if (capture) begin
        pending   <= 1'b1;
        fstart_sh <= cfg_fword;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef FREQ_SWEEP_EN
  logic [ACC_W-1:0] fstop_sh;
  logic [ACC_W-1:0] fstep_sh;
  logic             mode_sh;
  logic [ACC_W-1:0] act_fstart;
  logic [ACC_W-1:0] act_fstop;
  logic [ACC_W-1:0] act_fstep;
  logic [ACC_W:0]   up_sum;
  logic [ACC_W:0]   dn_diff;
  logic             sweep_ok;
  logic             tick;

  // active bounds are separate from the shadow so a queued update cannot disturb a running sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstop_sh   <= '0;
      fstep_sh   <= '0;
      mode_sh    <= MODE_FIXED;
      act_fstart <= '0;
      act_fstop  <= '0;
      act_fstep  <= '0;
    end else begin
      if (capture) begin
        fstop_sh <= cfg_fstop;
        fstep_sh <= cfg_fstep;
        mode_sh  <= cfg_mode;
      end
      if (apply) begin
        act_fstart <= fstart_sh;
        act_fstop  <= fstop_sh;
        act_fstep  <= fstep_sh;
      end
    end
  end

  sweep_tick_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .clear (apply),
    .tick  (tick)
  );

  assign sweep_ok = (mode_sh == MODE_SWEEP) && (fstop_sh > fstart_sh) && (fstep_sh != '0);
  assign up_sum   = {1'b0, fword_cur} + {1'b0, act_fstep};
  // top bit set means the subtraction borrowed
  assign dn_diff  = {1'b0, fword_cur} - {1'b0, act_fstep};
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_fstop, cfg_fstep, cfg_mode};
`endif

  always_comb begin
    state_nxt = state;
    fword_nxt = fword_cur;
    if (apply) begin
      fword_nxt = fstart_sh;
`ifdef FREQ_SWEEP_EN
      state_nxt = sweep_ok ? UP : FIXED;
`else
      state_nxt = FIXED;
`endif
    end
`ifdef FREQ_SWEEP_EN
    else if (tick) begin
      case (state)
        UP: begin
          if (up_sum >= {1'b0, act_fstop}) begin
            fword_nxt = act_fstop;
            state_nxt = DOWN;
          end else begin
            fword_nxt = up_sum[ACC_W-1:0];
          end
        end
        DOWN: begin
          if (dn_diff[ACC_W] || (dn_diff[ACC_W-1:0] <= act_fstart)) begin
            fword_nxt = act_fstart;
            state_nxt = UP;
          end else begin
            fword_nxt = dn_diff[ACC_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fword_cur <= '0;
    end else begin
      state     <= state_nxt;
      fword_cur <= fword_nxt;
    end
  end

endmodule

`default_nettype wire
